// File: rtl/seg_frame_feeder_if.sv
// Shifter-side bus of the 7-segment frame feeder: parallel frame, start strobe, idle flag.
// Latency: none, wires only.
// Backpressure: the shifter holds sen low while shifting; the feeder keeps data frozen meanwhile.
// Ports:
//   data  feeder -> shifter  8*DIGITS  frame, byte i = data[8i+7:8i], {dp,g,f,e,d,c,b,a} active-low
//   sync  feeder -> shifter  1         transfer start request, registered
//   sen   shifter -> feeder  1         1 = idle/hold, 0 = shifting
interface seg_frame_feeder_if #(
   parameter int DIGITS = 8
);
   logic [8*DIGITS-1:0] data;
   logic                sync;
   logic                sen;

   modport master (output data, output sync, input sen);
   modport slave  (input data, input sync, output sen);
endinterface

// File: rtl/seg_frame_feeder.sv
// Encodes packed hex nibbles into active-low 7-seg bytes and hands the frame to the serial shifter.
// Latency: trigger sampled at edge N -> byte i written at N+1+i, sync high after edge N+DIGITS.
// Backpressure: waits on sen (low = shifting); requests arriving while busy collapse into one pending frame.
// Ports: clk, rstn (async active-low); value[4*DIGITS], dp_mask/digit_en[DIGITS], upd strobe in;
//        busy out (frame latch to transfer end); shf = shifter bus (data/sync out, sen in).
// Build option: define SEG_BLINK_EN to add blink_mask[DIGITS] and a frame counter that blanks
//        masked digits while frame_cnt[4] is set.
module seg_frame_feeder #(
   parameter int DIGITS       = 8,
   parameter int REFRESH_DIV  = 50000,
   parameter int SYNC_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dp_mask,
   input  logic [DIGITS-1:0]   digit_en,
`ifdef SEG_BLINK_EN
   input  logic [DIGITS-1:0]   blink_mask,
`endif
   input  logic                upd,
   output logic                busy,
   seg_frame_feeder_if.master  shf
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int TO_W  = $clog2(SYNC_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ENCODE, SYNC, XFER} state_t;

   state_t              state, state_nxt;
   logic [RC_W-1:0]     ref_cnt;
   logic                tick;
   logic                req;
   logic [IDX_W-1:0]    idx;
   logic [TO_W-1:0]     to_cnt;
   logic                pending, pending_nxt;
   logic                busy_nxt;
   logic                sync_q, sync_nxt;
   logic [8*DIGITS-1:0] data_q;
   logic                latch, enc_wr, frame_done;
   logic [4*DIGITS-1:0] val_sh;
   logic [DIGITS-1:0]   dp_sh, en_sh;
   logic [3:0]          nib;
   logic                blank;
   logic [7:0]          enc_byte;
`ifdef SEG_BLINK_EN
   logic [DIGITS-1:0]   blink_sh;
   logic [4:0]          frame_cnt;
`endif

   assign shf.data = data_q;
   assign shf.sync = sync_q;

   // Free-running refresh divider; it keeps counting in every state so the refresh rate is fixed.
   assign tick = (ref_cnt == RC_W'(REFRESH_DIV - 1));
   assign req  = upd | tick;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ref_cnt <= '0;
      end else if (tick) begin
         ref_cnt <= '0;
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

   // Lit segments {g,f,e,d,c,b,a}, active-high here and inverted on output.
   function automatic logic [6:0] seg_lit(input logic [3:0] n);
      case (n)
         4'h0:    seg_lit = 7'h3F;
         4'h1:    seg_lit = 7'h06;
         4'h2:    seg_lit = 7'h5B;
         4'h3:    seg_lit = 7'h4F;
         4'h4:    seg_lit = 7'h66;
         4'h5:    seg_lit = 7'h6D;
         4'h6:    seg_lit = 7'h7D;
         4'h7:    seg_lit = 7'h07;
         4'h8:    seg_lit = 7'h7F;
         4'h9:    seg_lit = 7'h6F;
         4'hA:    seg_lit = 7'h77;
         4'hB:    seg_lit = 7'h7C;
         4'hC:    seg_lit = 7'h39;
         4'hD:    seg_lit = 7'h5E;
         4'hE:    seg_lit = 7'h79;
         default: seg_lit = 7'h71;
      endcase
   endfunction

   always_comb begin
      nib = val_sh[{idx, 2'b00} +: 4];
`ifdef SEG_BLINK_EN
      blank = blink_sh[idx] & frame_cnt[4];
`else
      blank = 1'b0;
`endif
      enc_byte = (en_sh[idx] && !blank) ? {~dp_sh[idx], ~seg_lit(nib)} : 8'hFF;
   end

   always_comb begin
      state_nxt   = state;
      sync_nxt    = sync_q;
      busy_nxt    = busy;
      // Any request seen outside an IDLE launch is remembered; repeats collapse into one.
      pending_nxt = pending | req;
      latch       = 1'b0;
      enc_wr      = 1'b0;
      frame_done  = 1'b0;
      case (state)
         IDLE: begin
            if (req || pending) begin
               latch       = 1'b1;
               pending_nxt = 1'b0;
               busy_nxt    = 1'b1;
               state_nxt   = ENCODE;
            end
         end
         ENCODE: begin
            enc_wr = 1'b1;
            if (idx == IDX_W'(DIGITS - 1)) begin
               sync_nxt  = 1'b1;
               state_nxt = SYNC;
            end
         end
         SYNC: begin
            if (!shf.sen) begin
               sync_nxt  = 1'b0;
               state_nxt = XFER;
            end else if (to_cnt == TO_W'(SYNC_TIMEOUT - 1)) begin
               // Shifter never answered: abandon this attempt and relaunch from IDLE.
               sync_nxt    = 1'b0;
               busy_nxt    = 1'b0;
               pending_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         XFER: begin
            if (shf.sen) begin
               busy_nxt   = 1'b0;
               frame_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         sync_q  <= 1'b0;
         busy    <= 1'b0;
         pending <= 1'b0;
      end else begin
         state   <= state_nxt;
         sync_q  <= sync_nxt;
         busy    <= busy_nxt;
         pending <= pending_nxt;
      end
   end

   // data only changes in ENCODE, so the shifter sees a frozen frame from sync rise to the end of XFER.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx    <= '0;
         to_cnt <= '0;
         data_q <= '1;
         val_sh <= '0;
         dp_sh  <= '0;
         en_sh  <= '0;
`ifdef SEG_BLINK_EN
         blink_sh  <= '0;
         frame_cnt <= '0;
`endif
      end else begin
         if (latch) begin
            idx    <= '0;
            val_sh <= value;
            dp_sh  <= dp_mask;
            en_sh  <= digit_en;
`ifdef SEG_BLINK_EN
            blink_sh <= blink_mask;
`endif
         end else if (enc_wr) begin
            data_q[{idx, 3'b000} +: 8] <= enc_byte;
            idx                        <= idx + 1'b1;
         end
         to_cnt <= (state == SYNC) ? to_cnt + 1'b1 : '0;
`ifdef SEG_BLINK_EN
         if (frame_done) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_seg_frame_feeder.sv
// Bench for seg_frame_feeder: directed sequence plus randomized frames against a segment-letter model.
// Latency: n/a (testbench).
// Backpressure: a scripted shifter drives sen with chosen delays and transfer lengths.
module tb_seg_frame_feeder;
   localparam int DIGITS = 8;
   localparam int DIV    = 200;
   localparam int TMO    = 15;

   logic                clk = 1'b0;
   logic                rstn;
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   dp_mask;
   logic [DIGITS-1:0]   digit_en;
   logic [DIGITS-1:0]   blink_mask;
   logic                upd;
   logic                busy;

   seg_frame_feeder_if #(.DIGITS(DIGITS)) shf ();

   seg_frame_feeder #(
      .DIGITS(DIGITS),
      .REFRESH_DIV(DIV),
      .SYNC_TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .value(value),
      .dp_mask(dp_mask),
      .digit_en(digit_en),
`ifdef SEG_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .upd(upd),
      .busy(busy),
      .shf(shf)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;          // posedges since the last reset release
   int frames_done = 0;  // completed transfers since reset
   logic [63:0] exp_frame;

   // Lit segment letters per hex digit.
   string seg_tab [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   function automatic logic [7:0] ref_byte(input logic [3:0] n, input logic dp, input logic en,
                                           input logic blank);
      logic [6:0] lit;
      string s;
      lit = '0;
      s = seg_tab[n];
      for (int i = 0; i < s.len(); i++) lit[3'(int'(s[i]) - 97)] = 1'b1;
      if (!en || blank) return 8'hFF;
      return ~{dp, lit};
   endfunction

   function automatic logic [63:0] ref_frame(input logic [31:0] v, input logic [7:0] dp,
                                             input logic [7:0] en, input logic [7:0] bl,
                                             input int fidx);
      logic [63:0] f;
      logic odd;
      odd = ((fidx >> 4) & 1) == 1;
      for (int i = 0; i < DIGITS; i++)
         f[8*i +: 8] = ref_byte(v[4*i +: 4], dp[i], en[i], bl[i] && odd);
      return f;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_inputs(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en);
      value    = v;
      dp_mask  = dp;
      digit_en = en;
`ifdef SEG_BLINK_EN
      exp_frame = ref_frame(v, dp, en, blink_mask, frames_done);
`else
      exp_frame = ref_frame(v, dp, en, 8'h00, frames_done);
`endif
   endtask

   task automatic set_random();
      set_inputs($urandom, 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF);
   endtask

   // Pulse upd, keeping the whole frame (span cycles) clear of a refresh tick.
   task automatic safe_trigger(input int span);
      while ((cyc % DIV) >= DIV - span && (cyc % DIV) != DIV - 1) step();
      upd = 1'b1;
      step();
      upd = 1'b0;
   endtask

   // Called #1 after the edge that sampled the trigger; serves one frame as the shifter.
   task automatic run_frame(input int dly, input int len, input bit pulse_upd);
      step();
      chk("byte0_first_edge", 64'(shf.data[7:0]), 64'(exp_frame[7:0]));
      chk("busy_encode", 64'(busy), 64'd1);
      for (int k = 2; k < DIGITS; k++) step();
      chk("sync_low_encode", 64'(shf.sync), 64'd0);
      step();
      chk("sync_rise", 64'(shf.sync), 64'd1);
      chk("frame_data", shf.data, exp_frame);
      for (int k = 1; k < dly; k++) begin
         step();
         chk("sync_hold", 64'(shf.sync), 64'd1);
      end
      shf.sen = 1'b0;
      step();
      chk("sync_fall", 64'(shf.sync), 64'd0);
      chk("data_stable", shf.data, exp_frame);
      for (int k = 1; k < len; k++) begin
         if (pulse_upd && (k == 2 || k == 5)) upd = 1'b1;
         step();
         upd = 1'b0;
         chk("busy_xfer", 64'(busy), 64'd1);
         chk("data_stable", shf.data, exp_frame);
      end
      shf.sen = 1'b1;
      step();
      chk("busy_fall", 64'(busy), 64'd0);
      chk("sync_idle", 64'(shf.sync), 64'd0);
      chk("data_after", shf.data, exp_frame);
      frames_done++;
   endtask

   task automatic idle_check(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         chk("no_extra_frame", 64'({busy, shf.sync}), 64'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn       = 1'b0;
      upd        = 1'b0;
      shf.sen    = 1'b1;
      value      = '0;
      dp_mask    = '0;
      digit_en   = '0;
      blink_mask = '0;
      exp_frame  = '1;
      step();
      step();
      chk("reset_sync", 64'(shf.sync), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_data", shf.data, 64'hFFFF_FFFF_FFFF_FFFF);
      rstn = 1'b1;
      cyc  = 0;

      // Directed frame with the known byte pattern; only byte0 is fresh after the first edge.
      set_inputs(32'h0123_89AF, 8'h01, 8'hFF);
      chk("model_frame", exp_frame, 64'hC0F9_A4B0_8090_880E);
      step();
      upd = 1'b1;
      step();
      upd = 1'b0;
      run_frame(3, 17, 1'b0);

      // A few random frames with varied shifter timing.
      for (int f = 0; f < 3; f++) begin
         set_random();
         safe_trigger(40);
         run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 16)), 1'b0);
      end

      // Two upd pulses plus the tick at edge 200 during XFER -> one extra frame right after.
      while (cyc < 184) step();
      set_inputs(32'hFEDC_BA98, 8'hA5, 8'hFF);
      upd = 1'b1;
      step();
      upd = 1'b0;
      run_frame(3, 17, 1'b1);
      set_random();
      step();
      chk("pending_start", 64'(busy), 64'd1);
      run_frame(2, 5, 1'b0);
      idle_check(20);

      // Refresh tick alone launches a frame.
      while (cyc < 399) step();
      set_random();
      step();
      chk("tick_start", 64'(busy), 64'd1);
      run_frame(2, 8, 1'b0);

      // upd coinciding with a tick gives a single frame.
      while (cyc < 599) step();
      set_random();
      upd = 1'b1;
      step();
      upd = 1'b0;
      run_frame(3, 6, 1'b0);
      idle_check(20);

      for (int f = 0; f < 4; f++) begin
         set_random();
         safe_trigger(40);
         run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 16)), 1'b0);
      end

      // No shifter: sync times out, frame retries, then a reset pulse lands mid-retry.
      set_random();
      safe_trigger(60);
      for (int k = 0; k < DIGITS; k++) step();
      chk("to_sync_rise", 64'(shf.sync), 64'd1);
      chk("to_frame_data", shf.data, exp_frame);
      for (int k = 1; k < TMO; k++) step();
      chk("to_sync_last_high", 64'(shf.sync), 64'd1);
      step();
      chk("to_sync_drop", 64'(shf.sync), 64'd0);
      step();
      chk("retry_busy", 64'(busy), 64'd1);
      for (int k = 0; k < DIGITS; k++) step();
      chk("retry_sync", 64'(shf.sync), 64'd1);
      chk("retry_data", shf.data, exp_frame);
      step();
      step();
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_sync", 64'(shf.sync), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_data", shf.data, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      step();
      rstn        = 1'b1;
      cyc         = 0;
      frames_done = 0;
      idle_check(10);

`ifdef SEG_BLINK_EN
      // Digit 7 blinks: normal in frames 0-15, blanked in frames 16-31.
      blink_mask = 8'h80;
      for (int f = 0; f < 32; f++) begin
         set_inputs($urandom, 8'($urandom), 8'hFF);
         safe_trigger(20);
         run_frame(1, 1, 1'b0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
